// File: rtl/aes_round_sequencer_if.sv
`timescale 1ns/1ps
// aes_round_sequencer_if: groups the issue, key-schedule and vector-ALU signals of the
// AES round sequencer.
//   master: the sequencer (drives busy/done/data_out, key_req/key_round, alu_op/alu_src_*)
//   slave : its environment (drives start/data_in/abort, key_valid/key_in, alu_result)
interface aes_round_sequencer_if;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;
  localparam int unsigned OP_W  = 5;

  // issue side
  logic             start;
  logic [BLK_W-1:0] data_in;
  logic             abort;
  logic             busy;
  logic             done;
  logic [BLK_W-1:0] data_out;
  // key-schedule handshake
  logic             key_req;
  logic [RND_W-1:0] key_round;
  logic             key_valid;
  logic [BLK_W-1:0] key_in;
  // vector ALU
  logic [OP_W-1:0]  alu_op;
  logic [BLK_W-1:0] alu_src_a;
  logic [BLK_W-1:0] alu_src_b;
  logic [BLK_W-1:0] alu_result;

  modport master (
    input  start, data_in, abort, key_valid, key_in, alu_result,
    output busy, done, data_out, key_req, key_round, alu_op, alu_src_a, alu_src_b
  );

  modport slave (
    output start, data_in, abort, key_valid, key_in, alu_result,
    input  busy, done, data_out, key_req, key_round, alu_op, alu_src_a, alu_src_b
  );
endinterface

// File: rtl/aes_round_sequencer.sv
`timescale 1ns/1ps
// aes_round_sequencer: drives an external 128-bit vector ALU through a complete AES-128
// encryption (initial AddRoundKey, 9 full rounds, final round without MixColumns),
// keeping the cipher state locally and fetching each round key over a req/valid handshake.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   bus   - master side of aes_round_sequencer_if:
//           start/data_in/abort -> busy/done/data_out (issue logic)
//           key_req/key_round   <- key_valid/key_in   (key-schedule provider)
//           alu_op/alu_src_a/alu_src_b <- alu_result  (vector ALU)
module aes_round_sequencer #(
  parameter int unsigned ALU_LAT      = 0,
  parameter logic [4:0]  OP_NOP       = 5'b00000,
  parameter logic [4:0]  OP_SUBBYTES  = 5'b10010,
  parameter logic [4:0]  OP_ARK       = 5'b10011,
  parameter logic [4:0]  OP_SHIFTROWS = 5'b10100,
  parameter logic [4:0]  OP_MIXCOL    = 5'b10101
) (
  input logic                   clk,
  input logic                   rst,
  aes_round_sequencer_if.master bus
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned HOLD_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(10);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_KEY, S_OP, S_DONE} state_t;
  typedef enum logic [1:0] {STEP_SUB, STEP_SHR, STEP_MIX, STEP_ARK} step_t;

  state_t            state_q, state_d;
  step_t             step_q, step_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [BLK_W-1:0]  st_q, st_d;
  logic [BLK_W-1:0]  key_q, key_d;
  logic [BLK_W-1:0]  dout_q, dout_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              key_req_q, key_req_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [BLK_W-1:0]  src_b_q, src_b_d;

  function automatic logic [OP_W-1:0] step_op(input step_t s);
    case (s)
      STEP_SUB: step_op = OP_SUBBYTES;
      STEP_SHR: step_op = OP_SHIFTROWS;
      STEP_MIX: step_op = OP_MIXCOL;
      default:  step_op = OP_ARK;
    endcase
  endfunction

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      step_q    <= STEP_SUB;
      round_q   <= '0;
      hold_q    <= '0;
      st_q      <= '0;
      key_q     <= '0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      key_req_q <= 1'b0;
      op_q      <= OP_NOP;
      src_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      round_q   <= round_d;
      hold_q    <= hold_d;
      st_q      <= st_d;
      key_q     <= key_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      key_req_q <= key_req_d;
      op_q      <= op_d;
      src_b_q   <= src_b_d;
    end
  end

  // next state; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    hold_d  = hold_q;
    st_d    = st_q;
    key_d   = key_q;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          st_d    = bus.data_in;
          round_d = '0;
          hold_d  = '0;
          state_d = S_KEY;
        end
      end
      S_KEY: begin
        // abort beats a simultaneous key handshake
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.key_valid) begin
          key_d   = bus.key_in;
          step_d  = (round_q == '0) ? STEP_ARK : STEP_SUB;
          hold_d  = '0;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (bus.abort) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
          st_d   = bus.alu_result;
          case (step_q)
            STEP_SUB: step_d = STEP_SHR;
            // the final round skips MixColumns
            STEP_SHR: step_d = (round_q == LAST_ROUND) ? STEP_ARK : STEP_MIX;
            STEP_MIX: step_d = STEP_ARK;
            default: begin
              if (round_q == LAST_ROUND) begin
                dout_d  = bus.alu_result;
                state_d = S_DONE;
              end else begin
                round_d = round_q + RND_W'(1);
                state_d = S_KEY;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d    = (state_d == S_KEY) || (state_d == S_OP);
    done_d    = (state_d == S_DONE);
    key_req_d = (state_d == S_KEY);
    op_d      = (state_d == S_OP) ? step_op(step_d) : OP_NOP;
    src_b_d   = ((state_d == S_OP) && (step_d == STEP_ARK)) ? key_d : '0;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_out  = dout_q;
  assign bus.key_req   = key_req_q;
  assign bus.key_round = round_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_src_a = st_q;
  assign bus.alu_src_b = src_b_q;

endmodule
